// File: rtl/csr_timer_int.sv
// CSR timer/interrupt unit: NUM_TIMERS down-counters with TI pending, TID, a 64-bit stable counter,
// synchronised HWI lines and the ESTAT.IS / has_int composition. Reads are combinational, writes land next cycle.
module csr_timer_int #(
   parameter int          NUM_TIMERS = 1,
   parameter int          CNT_WIDTH  = 32,
   parameter logic [31:0] CORE_ID    = 32'h0,
   parameter int          HWI_SYNC   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [13:0]           csr_raddr,
   output logic [31:0]           csr_rdata,
   output logic                  csr_rhit,
   input  logic                  csr_wr_en,
   input  logic [13:0]           csr_waddr,
   input  logic [31:0]           csr_wdata,
   input  logic [7:0]            hwi_in,
   input  logic                  crmd_ie,
   input  logic [12:0]           ecfg_lie,
   output logic [12:0]           estat_is,
   output logic [NUM_TIMERS-1:0] timer_pending,
   output logic                  has_int,
   output logic [63:0]           stable_cnt,
   output logic [31:0]           csr_tid_diff,
   output logic [31:0]           csr_tcfg_diff,
   output logic [31:0]           csr_tval_diff,
   output logic [31:0]           csr_ticlr_diff
);

   localparam logic [13:0]          ADDR_TID   = 14'h040;
   localparam logic [13:0]          ADDR_ESTAT = 14'h005;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   function automatic logic [13:0] tcfg_addr(input int k);
      return (k == 0) ? 14'h041 : 14'(448 + 4 * k);
   endfunction

   function automatic logic [13:0] tval_addr(input int k);
      return (k == 0) ? 14'h042 : 14'(449 + 4 * k);
   endfunction

   function automatic logic [13:0] ticlr_addr(input int k);
      return (k == 0) ? 14'h044 : 14'(450 + 4 * k);
   endfunction

   logic [CNT_WIDTH-1:0]  tcfg_q  [NUM_TIMERS];
   logic [CNT_WIDTH-1:0]  tcfg_d  [NUM_TIMERS];
   logic [CNT_WIDTH-1:0]  tval_q  [NUM_TIMERS];
   logic [CNT_WIDTH-1:0]  tval_d  [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] pend_q, pend_d;
   logic [NUM_TIMERS-1:0] armed_q, armed_d;
   logic [31:0]           tid_q, tid_d;
   logic [1:0]            swi_q, swi_d;
   logic [7:0]            hwi_s1_q, hwi_s2_q;
   logic [7:0]            hwi_sync;
   logic [63:0]           stable_q;

   // Timer channels: a TCFG write re-arms and preloads, overriding that cycle's count step.
   always_comb begin
      for (int k = 0; k < NUM_TIMERS; k++) begin
         tcfg_d[k]  = tcfg_q[k];
         tval_d[k]  = tval_q[k];
         armed_d[k] = armed_q[k];
         pend_d[k]  = pend_q[k];
         if (csr_wr_en && csr_waddr == ticlr_addr(k) && csr_wdata[0]) begin
            pend_d[k] = 1'b0;
         end
         if (csr_wr_en && csr_waddr == tcfg_addr(k)) begin
            tcfg_d[k]  = csr_wdata[CNT_WIDTH-1:0];
            tval_d[k]  = {csr_wdata[CNT_WIDTH-1:2], 2'b00};
            armed_d[k] = 1'b1;
         end else if (tcfg_q[k][0]) begin
            if (tval_q[k] != '0) begin
               tval_d[k] = tval_q[k] - CNT_ONE;
               if (tval_q[k] == CNT_ONE && armed_q[k]) begin
                  pend_d[k] = 1'b1;
               end
            end else if (tcfg_q[k][1]) begin
               tval_d[k] = {tcfg_q[k][CNT_WIDTH-1:2], 2'b00};
            end else begin
               tval_d[k]  = '1;
               armed_d[k] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      tid_d = tid_q;
      swi_d = swi_q;
      if (csr_wr_en && csr_waddr == ADDR_TID) begin
         tid_d = csr_wdata;
      end
      if (csr_wr_en && csr_waddr == ADDR_ESTAT) begin
         swi_d = csr_wdata[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tid_q    <= CORE_ID;
         swi_q    <= '0;
         hwi_s1_q <= '0;
         hwi_s2_q <= '0;
         stable_q <= '0;
         pend_q   <= '0;
         armed_q  <= '0;
         for (int k = 0; k < NUM_TIMERS; k++) begin
            tcfg_q[k] <= '0;
            tval_q[k] <= '0;
         end
      end else begin
         tid_q    <= tid_d;
         swi_q    <= swi_d;
         hwi_s1_q <= hwi_in;
         hwi_s2_q <= hwi_s1_q;
         stable_q <= stable_q + 64'd1;
         pend_q   <= pend_d;
         armed_q  <= armed_d;
         for (int k = 0; k < NUM_TIMERS; k++) begin
            tcfg_q[k] <= tcfg_d[k];
            tval_q[k] <= tval_d[k];
         end
      end
   end

   // With HWI_SYNC=0 the second flop is left unloaded and trims away.
   assign hwi_sync = (HWI_SYNC != 0) ? hwi_s2_q : hwi_s1_q;

   assign estat_is = {1'b0, |pend_q, 1'b0, hwi_sync, swi_q};
   assign has_int  = crmd_ie & (|(estat_is & ecfg_lie & 13'h1BFF));

   always_comb begin
      csr_rdata = '0;
      csr_rhit  = 1'b0;
      if (csr_raddr == ADDR_TID) begin
         csr_rhit  = 1'b1;
         csr_rdata = tid_q;
      end
      if (csr_raddr == ADDR_ESTAT) begin
         csr_rhit  = 1'b1;
         csr_rdata = {19'b0, estat_is};
      end
      for (int k = 0; k < NUM_TIMERS; k++) begin
         if (csr_raddr == tcfg_addr(k)) begin
            csr_rhit  = 1'b1;
            csr_rdata = 32'(tcfg_q[k]);
         end
         if (csr_raddr == tval_addr(k)) begin
            csr_rhit  = 1'b1;
            csr_rdata = 32'(tval_q[k]);
         end
         if (csr_raddr == ticlr_addr(k)) begin
            csr_rhit  = 1'b1;
            csr_rdata = '0;
         end
      end
   end

   assign timer_pending  = pend_q;
   assign stable_cnt     = stable_q;
   assign csr_tid_diff   = tid_q;
   assign csr_tcfg_diff  = 32'(tcfg_q[0]);
   assign csr_tval_diff  = 32'(tval_q[0]);
   assign csr_ticlr_diff = '0;

endmodule

// File: doc/csr_timer_int.md
Name: csr_timer_int

Overview:
- Parametrised timer and interrupt-status unit for the LoongArch CSR file.
- Replaces the single fixed timer with NUM_TIMERS independent down-counters and a 64-bit stable counter.
- Builds the ESTAT.IS vector and the has_int request.
- The main CSR block forwards TID/TCFG/TVAL/TICLR/ESTAT accesses here and muxes csr_rdata in whenever csr_rhit=1.

Parameters:
NUM_TIMERS, 1, number of timer channels (1..4)
CNT_WIDTH, 32, TVAL width in bits (8..32); INITVAL field is CNT_WIDTH-2 bits
CORE_ID, 0, reset value of TID
HWI_SYNC, 1, 1 = hwi_in passes through a 2-flop synchroniser; 0 = single register stage

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
csr_raddr  in  14  CSR read address
csr_rdata  out  32  read data for addresses owned by this block; 0 otherwise
csr_rhit  out  1  csr_raddr decodes to a register owned by this block
csr_wr_en  in  1  CSR write strobe
csr_waddr  in  14  CSR write address
csr_wdata  in  32  CSR write data
hwi_in  in  8  asynchronous hardware interrupt lines
crmd_ie  in  1  CRMD.IE
ecfg_lie  in  13  ECFG.LIE
estat_is  out  13  ESTAT.IS[12:0] for merging into ESTAT
timer_pending  out  NUM_TIMERS  per-channel TI pending
has_int  out  1  interrupt request to the exception logic
stable_cnt  out  64  free-running counter, for rdcntvl/rdcntvh
csr_tid_diff  out  32  TID
csr_tcfg_diff  out  32  channel 0 TCFG
csr_tval_diff  out  32  channel 0 TVAL
csr_ticlr_diff  out  32  always 0

Behaviour:
- Reset: clk and reset as already decided (reset synchronous, active-high).
- Values on reset:
  - TID=CORE_ID.
  - All TCFG, TVAL, pending and armed bits = 0.
  - SWI=0, synchroniser flops=0, stable_cnt=0.
  - has_int=0, estat_is=0.
- Address map:
  - TID 0x40.
  - Channel 0: TCFG 0x41, TVAL 0x42, TICLR 0x44.
  - Channel k>=1: TCFG 0x1C0+4k, TVAL 0x1C1+4k, TICLR 0x1C2+4k.
  - ESTAT 0x5 (IS field only).
  - Addresses for channels >= NUM_TIMERS do not hit.
- Reads:
  - Combinational from current register state. No write bypass: a write becomes visible on the cycle after csr_wr_en.
  - TCFG reads as {0, INITVAL, PERIODIC, EN}.
  - TVAL is zero-extended to 32 bits.
  - TICLR reads 0.
  - ESTAT reads {19'b0, estat_is}.
- TCFG write (channel k):
  - Fields: EN=wdata[0], PERIODIC=wdata[1], INITVAL=wdata[CNT_WIDTH-1:2].
  - TVAL <= {INITVAL, 2'b00}; armed <= 1.
  - Takes priority over that cycle's decrement/reload.
- TVAL writes are ignored (read-only).
- Counting, each cycle with EN=1 and no TCFG write:
  - TVAL!=0: TVAL <= TVAL-1.
  - If TVAL==1 and armed: pending <= 1.
  - TVAL==0 and PERIODIC=1: TVAL <= {INITVAL, 2'b00}; armed stays 1.
  - TVAL==0 and PERIODIC=0: TVAL <= all-ones (CNT_WIDTH bits); armed <= 0, so no further interrupt until the next TCFG write.
  - INITVAL=0 never raises pending, because it has no 1->0 transition.
- EN=0: TVAL holds.
- TICLR write with wdata[0]=1 clears pending[k]. If a set event occurs in the same cycle, set wins.
- ESTAT write: SWI[1:0] <= wdata[1:0]. All other IS bits ignore writes.
- estat_is composition:
  - [1:0] SWI.
  - [9:2] hwi_in after the synchroniser (latency 2 cycles with HWI_SYNC=1, 1 cycle with HWI_SYNC=0).
  - [10] 0.
  - [11] |timer_pending.
  - [12] 0.
- has_int = crmd_ie & |(estat_is & ecfg_lie & 13'h1BFF). Combinational from registered state, with no extra latency.
- stable_cnt increments every cycle and wraps from 2^64-1 to 0.
- TID: fully writable, 32 bits.

Test Plan:
- TCFG0 <= 0x0000_0009 (EN, INITVAL=2 -> TVAL=8), hold -> TVAL reads 8,7,..,1,0 on successive cycles; timer_pending[0]=1 from the cycle TVAL reads 0; TVAL then reloads to 0xFFFF_FFFF; no second set after TICLR.
- TCFG0 <= 0x0B (periodic, INITVAL=2), crmd_ie=1, ecfg_lie[11]=1 -> has_int asserts every 9 cycles; TICLR write of 1 on the set cycle -> pending stays 1.
- hwi_in[3]=1 pulse for 3 cycles with HWI_SYNC=1 -> estat_is[5] rises 2 cycles later; with ecfg_lie[5]=0 -> has_int stays 0.
- ESTAT <= 0xFFFF_FFFF -> read returns 0x0000_0003 plus live HWI/TI bits; bit 10 is never set.
- NUM_TIMERS=2: channels 0 and 1 programmed with INITVAL 1 and 3 -> pending[0] at cycle 4, pending[1] at cycle 12; addresses 0x1C8..0x1CA have csr_rhit=0.
- Reset asserted mid-count (TVAL=5) -> next cycle TVAL=0, EN=0, pending=0, stable_cnt=0, TID=CORE_ID.
